univ_shift_reg: RTL
===================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, register width in bits; legal range WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit: operation enable; low means hold.
REQ-005 The block SHALL have port mode, input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 The block SHALL have port sin_r, input, 1 bit: serial data entering the MSB on a right shift.
REQ-007 The block SHALL have port sin_l, input, 1 bit: serial data entering the LSB on a left shift.
REQ-008 The block SHALL have port pin, input, WIDTH bits: parallel load data.
REQ-009 The block SHALL have port q, output, WIDTH bits: register contents.
REQ-010 The block SHALL have port sout_r, output, 1 bit: combinational copy of q[0], the right-shift serial out.
REQ-011 The block SHALL have port sout_l, output, 1 bit: combinational copy of q[WIDTH-1], the left-shift serial out.
REQ-012 The block SHALL have port word_valid, output, 1 bit: one-cycle pulse marking completion of a WIDTH-shift word.

Function
REQ-013 When en=1 and mode=01, q SHALL become {sin_r, q[WIDTH-1:1]} at the next rising clk edge.
REQ-014 When en=1 and mode=10, q SHALL become {q[WIDTH-2:0], sin_l} at the next rising clk edge.
REQ-015 When en=1 and mode=11, q SHALL become pin at the next rising clk edge, giving a latency of one cycle.
REQ-016 When en=0 or mode=00, q SHALL hold its value; en=0 SHALL override every mode.
REQ-017 An internal shift counter, ceil(log2(WIDTH)) bits wide with range 0..WIDTH-1, SHALL increment on every enabled shift in either direction.
REQ-018 On the enabled shift taken while the counter equals WIDTH-1, the counter SHALL wrap to 0 and word_valid SHALL be registered high for exactly the following cycle.
REQ-019 word_valid SHALL be low in every cycle not covered by REQ-018, including hold cycles and en=0 cycles.
REQ-020 An enabled parallel load SHALL clear the counter to 0 and SHALL NOT assert word_valid.
REQ-021 A change of shift direction in the middle of a word SHALL NOT reset the counter; it SHALL continue counting.
REQ-022 Back-to-back words SHALL each pulse word_valid with no dead cycle between them, so the pulse recurs every WIDTH enabled shifts.

Reset
REQ-023 While rst=1, the block SHALL force q=0, counter=0 and word_valid=0 immediately, independent of clk.
REQ-024 Reset asserted mid-word SHALL discard the partial word, so the next word needs a full WIDTH shifts.
REQ-025 On the first rising clk edge after rst deasserts, the block SHALL operate normally.

Configuration
REQ-026 With macro UNIV_SHIFT_REG_WORD_VALID_EN defined, the shift counter and word_valid logic SHALL be built as specified in REQ-017 to REQ-022.
REQ-027 Without UNIV_SHIFT_REG_WORD_VALID_EN, no counter SHALL be synthesised, the word_valid port SHALL remain present and tied to constant 0, and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package shift_pkg SHALL hold the mode encoding constants MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD, and the 2-bit mode typedef.
REQ-029 Each bit SHALL be stored in an instance of the existing d_ff cell (ports clk, rst, set, d, q), with set tied low and the per-bit next-state mux placed in univ_shift_reg, in a generate loop over WIDTH.

Verification (WIDTH=4, macro defined unless stated)
REQ-030 The bench SHALL check async reset: q=1111, then rst pulsed high between clk edges -> q=0000 and word_valid=0 before the next edge.
REQ-031 The bench SHALL check parallel load: en=1, mode=11, pin=1011 -> q=1011 after one edge and word_valid stays 0.
REQ-032 The bench SHALL check serial-in, parallel-out: from q=0000 with mode=01, sin_r=1,0,1,1 on four edges -> q=1000, 0100, 1010, 1101, and word_valid high only in the cycle after the fourth edge.
REQ-033 The bench SHALL check parallel-in, serial-out: load 1001, then mode=10 with sin_l=0 for four edges -> sout_l reads 1,0,0,1 before the edges, and q ends at 0000.
REQ-034 The bench SHALL check enable and load interaction: two shifts, en=0 for three cycles (q and counter frozen), a load, then four shifts -> word_valid fires only after the fourth post-load shift.
REQ-035 The bench SHALL check the macro-undefined build: the REQ-032 stimulus -> identical q sequence with word_valid constant 0.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode encoding shared by the universal shift register
package shift_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/d_ff.sv
// rtl/d_ff.sv - single-bit storage cell with asynchronous reset and set
module d_ff (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic d,
  output logic q
);

  // Reset wins over set; both act without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst or posedge set) begin
    if (rst)
      q <= 1'b0;
    else if (set)
      q <= 1'b1;
    else
      q <= d;
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register; UNIV_SHIFT_REG_WORD_VALID_EN builds the word counter
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_t            mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             word_valid
);

  logic [WIDTH-1:0] q_next;

  // Next-state selection; en low forces hold regardless of mode.
  always_comb begin
    q_next = q;
    if (en) begin
      case (mode)
        MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
        MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
        MODE_LOAD: q_next = pin;
        default:   q_next = q;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff u_ff (
      .clk (clk),
      .rst (rst),
      .set (1'b0),
      .d   (q_next[i]),
      .q   (q[i])
    );
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

`ifdef UNIV_SHIFT_REG_WORD_VALID_EN
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;
  logic          wv_q;
  logic          shift_evt;
  logic          load_evt;

  assign shift_evt = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
  assign load_evt  = en && (mode == MODE_LOAD);

  // Count shifts in either direction; the shift that completes a word wraps and pulses word_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      wv_q <= 1'b0;
    end else begin
      wv_q <= 1'b0;
      if (load_evt) begin
        cnt <= '0;
      end else if (shift_evt) begin
        if (cnt == CNT_MAX) begin
          cnt  <= '0;
          wv_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign word_valid = wv_q;
`else
  assign word_valid = 1'b0;
`endif

endmodule
